s4_actividad3_alu: RTL and testbench

Registered M-bit ALU with status flags. Four operations are selected by a 2-bit opcode: subtract, add, bitwise OR and bitwise AND. It produces the M-bit result plus five flags {N,Z,C,V,P}. Used as the datapath arithmetic unit in the session-4 lab designs, with one-cycle registered outputs.

---
 rtl/s4_actividad3_alu.sv | 88 ++++++++
 tb/tb_s4_actividad3_alu.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/s4_actividad3_alu.sv
// Registered M-bit ALU: SUB/ADD/OR/AND with {N,Z,C,V,P} flags, one-cycle latency.
// Subtraction shares the adder by inverting B and injecting a carry-in of one.
module s4_actividad3_alu #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic [1:0]   OpCode,
  output logic [M-1:0] Result,
  output logic [4:0]   Flags
);

  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  logic         is_sub;
  logic [M-1:0] b_eff;
  logic [M-1:0] sum;
  logic         carry_out;
  logic [M-1:0] or_bits;
  logic [M-1:0] and_bits;

  logic [M-1:0] result_next;
  logic [4:0]   flags_next;
  logic         c_next;
  logic         v_next;

  logic [M-1:0] result_reg;
  logic [4:0]   flags_reg;

  assign is_sub = (OpCode == OP_SUB);

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_bitwise
      assign b_eff[gi]    = B[gi] ^ is_sub;
      assign or_bits[gi]  = A[gi] | B[gi];
      assign and_bits[gi] = A[gi] & B[gi];
    end
  endgenerate

  // Ripple-carry adder kept in one process so the carry chain is a local variable.
  always_comb begin
    logic c;
    sum = '0;
    c   = is_sub;
    for (int i = 0; i < M; i++) begin
      sum[i] = A[i] ^ b_eff[i] ^ c;
      c      = (A[i] & b_eff[i]) | (c & (A[i] ^ b_eff[i]));
    end
    carry_out = c;
  end

  always_comb begin
    result_next = sum;
    c_next      = 1'b0;
    v_next      = 1'b0;
    case (OpCode)
      OP_SUB, OP_ADD: begin
        result_next = sum;
        c_next      = carry_out;
        // Using b_eff makes the same sign rule cover both add and subtract.
        v_next      = (A[M-1] == b_eff[M-1]) && (sum[M-1] != A[M-1]);
      end
      OP_OR:   result_next = or_bits;
      OP_AND:  result_next = and_bits;
      default: result_next = sum;
    endcase
    flags_next = {result_next[M-1], ~|result_next, c_next, v_next, ^result_next};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      result_reg <= result_next;
      flags_reg  <= flags_next;
    end
  end

  assign Result = result_reg;
  assign Flags  = flags_reg;

endmodule

// File: tb/tb_s4_actividad3_alu.sv
// Bench for s4_actividad3_alu: directed vector table, then a random stream with a
// mid-stream reset pulse checked against an integer-arithmetic reference model.
module tb_s4_actividad3_alu;

  localparam int M = 4;

  logic         clk;
  logic         reset;
  logic [M-1:0] A;
  logic [M-1:0] B;
  logic [1:0]   OpCode;
  logic [M-1:0] Result;
  logic [4:0]   Flags;

  int checks;
  int errors;

  s4_actividad3_alu #(.M(M)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .OpCode (OpCode),
    .Result (Result),
    .Flags  (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [1:0]   op;
    logic [M-1:0] r;
    logic [4:0]   f;
  } vec_t;

  vec_t vecs [16];

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input int a, input int b, input int op,
                                output logic [M-1:0] r, output logic [4:0] f);
    int full, sa, sb, sres, res, ones;
    logic c, v;
    full = 1 << M;
    sa = (a >= full / 2) ? a - full : a;
    sb = (b >= full / 2) ? b - full : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin
        res  = (a - b + full) % full;
        c    = (a >= b);
        sres = sa - sb;
        v    = (sres > full / 2 - 1) || (sres < -(full / 2));
      end
      1: begin
        res  = (a + b) % full;
        c    = (a + b) >= full;
        sres = sa + sb;
        v    = (sres > full / 2 - 1) || (sres < -(full / 2));
      end
      2: res = a | b;
      default: res = a & b;
    endcase
    ones = 0;
    for (int i = 0; i < M; i++) ones += (res >> i) & 1;
    r = res[M-1:0];
    f = {res >= full / 2, res == 0, c, v, (ones % 2) == 1};
  endfunction

  task automatic check(input string name, input logic [M-1:0] er, input logic [4:0] ef);
    checks++;
    if (Result !== er || Flags !== ef) begin
      errors++;
      $display("FAIL %s: got Result=%b Flags=%b, expected Result=%b Flags=%b",
               name, Result, Flags, er, ef);
    end else begin
      $display("ok   %s: A=%b B=%b Op=%b -> Result=%b Flags=%b", name, A, B, OpCode, Result, Flags);
    end
  endtask

  task automatic drive(input logic rst, input logic [M-1:0] a, input logic [M-1:0] b,
                       input logic [1:0] op);
    reset  = rst;
    A      = a;
    B      = b;
    OpCode = op;
  endtask

  logic [M-1:0] exp_r, prev_r;
  logic [4:0]   exp_f, prev_f;
  logic         rnd_rst;
  logic [M-1:0] ra, rb;
  logic [1:0]   rop;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{1'b0, 4'b1010, 4'b0110, 2'b01, 4'b0000, 5'b00000};
    vecs[1]  = '{1'b0, 4'b0011, 4'b1111, 2'b00, 4'b0000, 5'b00000};
    vecs[2]  = '{1'b1, 4'b1111, 4'b0001, 2'b00, 4'b1110, 5'b10101};
    vecs[3]  = '{1'b1, 4'b1111, 4'b0001, 2'b01, 4'b0000, 5'b01100};
    vecs[4]  = '{1'b1, 4'b1111, 4'b0001, 2'b10, 4'b1111, 5'b10000};
    vecs[5]  = '{1'b1, 4'b1111, 4'b0001, 2'b11, 4'b0001, 5'b00001};
    vecs[6]  = '{1'b1, 4'b1111, 4'b0000, 2'b00, 4'b1111, 5'b10100};
    vecs[7]  = '{1'b1, 4'b1111, 4'b0000, 2'b01, 4'b1111, 5'b10000};
    vecs[8]  = '{1'b1, 4'b1111, 4'b0000, 2'b10, 4'b1111, 5'b10000};
    vecs[9]  = '{1'b1, 4'b1111, 4'b0000, 2'b11, 4'b0000, 5'b01000};
    vecs[10] = '{1'b1, 4'b0111, 4'b0001, 2'b01, 4'b1000, 5'b10011};
    vecs[11] = '{1'b1, 4'b1000, 4'b0001, 2'b00, 4'b0111, 5'b00111};
    vecs[12] = '{1'b1, 4'b0001, 4'b0010, 2'b00, 4'b1111, 5'b10000};
    vecs[13] = '{1'b1, 4'b0101, 4'b0101, 2'b00, 4'b0000, 5'b01100};
    vecs[14] = '{1'b0, 4'b0111, 4'b0001, 2'b01, 4'b0000, 5'b00000};
    vecs[15] = '{1'b1, 4'b1000, 4'b1000, 2'b01, 4'b0000, 5'b01110};

    drive(1'b0, '0, '0, 2'b00);
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].op);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].r, vecs[i].f);
    end

    // Random stream: outputs must hold the previous result until the next edge,
    // and a one-cycle reset pulse must zero the outputs then resume cleanly.
    drive(1'b1, 4'b0000, 4'b0000, 2'b01);
    @(posedge clk);
    #1;
    prev_r = Result;
    prev_f = Flags;
    model(0, 0, 1, exp_r, exp_f);
    check("rand_start", exp_r, exp_f);

    for (int k = 0; k < 120; k++) begin
      rnd_rst = !(k == 40 || k == 85);
      ra  = M'($urandom_range(0, (1 << M) - 1));
      rb  = M'($urandom_range(0, (1 << M) - 1));
      rop = 2'($urandom_range(0, 3));
      drive(rnd_rst, ra, rb, rop);
      @(negedge clk);
      check($sformatf("hold%0d", k), prev_r, prev_f);
      @(posedge clk);
      #1;
      if (rnd_rst) model(int'(ra), int'(rb), int'(rop), exp_r, exp_f);
      else begin
        exp_r = '0;
        exp_f = '0;
      end
      check($sformatf("rand%0d", k), exp_r, exp_f);
      prev_r = exp_r;
      prev_f = exp_f;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
